mmac_operand_feeder: RTL and testbench

//   Upstream sequencer for matrix_mac_unit. Buffers two M_SIZE x M_SIZE operand matrices A and B,

---
 rtl/mmac_operand_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_mmac_operand_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmac_operand_feeder.sv
// Operand sequencer for matrix_mac_unit: buffers A and B, streams A[i][k]/B[k][j] pairs and returns C[i][j].
// Optional abort input is enabled by defining MMAC_FEEDER_ABORT_EN.
module mmac_operand_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned M_SIZE     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      load_sel,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      start,
`ifdef MMAC_FEEDER_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy,
  output logic                      mac_clear,
  output logic                      mac_enable,
  output logic [DATA_WIDTH-1:0]     mac_a,
  output logic [DATA_WIDTH-1:0]     mac_b,
  input  logic [DATA_WIDTH-1:0]     mac_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(M_SIZE)-1:0] out_row,
  output logic [$clog2(M_SIZE)-1:0] out_col,
  output logic                      done
);

  localparam int unsigned IW    = $clog2(M_SIZE);
  localparam int unsigned DEPTH = M_SIZE * M_SIZE;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(M_SIZE - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] i_q, j_q, k_q;
  logic [IW-1:0] i_n, j_n, k_n;
  logic [PW-1:0] a_ptr, b_ptr;
  logic          a_full, b_full;

  logic [DATA_WIDTH-1:0] a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [DEPTH];

  logic                  load_fire;
  logic                  start_fire;
  logic                  abort_req;
  logic                  clear_n;
  logic                  enable_n;
  logic                  done_n;
  logic [DATA_WIDTH-1:0] a_n, b_n;

`ifdef MMAC_FEEDER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Loads and starts are only honoured while idle; a concurrent load wins over start.
  assign load_fire  = (state == S_IDLE) && load_valid;
  assign start_fire = (state == S_IDLE) && start && !load_valid && a_full && b_full;

  // Row-major flattening of a (row, col) pair into a buffer address.
  function automatic logic [PW-1:0] flat(input logic [IW-1:0] r, input logic [IW-1:0] c);
    return PW'(PW'(r) * PW'(M_SIZE) + PW'(c));
  endfunction

  // Next-state, next-counter and next-output decode.
  always_comb begin
    state_n = state;
    i_n     = i_q;
    j_n     = j_q;
    k_n     = k_q;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_fire) begin
          state_n = S_CLEAR;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      S_CLEAR: begin
        state_n = S_FEED;
        k_n     = '0;
      end
      S_FEED: begin
        if (k_q == IDX_LAST) begin
          state_n = S_CAPTURE;
        end else begin
          k_n = k_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_n = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (j_q == IDX_LAST) begin
            j_n = '0;
            i_n = (i_q == IDX_LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_n = j_q + 1'b1;
          end
          if ((i_q == IDX_LAST) && (j_q == IDX_LAST)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_CLEAR;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort_req && (state != S_IDLE)) begin
      state_n = S_IDLE;
      done_n  = 1'b0;
    end

    // MAC drive is registered so it lines up with the state it belongs to.
    clear_n  = (state_n == S_CLEAR);
    enable_n = (state_n == S_FEED);
    a_n      = enable_n ? a_mem[flat(i_n, k_n)] : '0;
    b_n      = enable_n ? b_mem[flat(k_n, j_n)] : '0;
  end

  // State, counters, load pointers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_ptr      <= '0;
      b_ptr      <= '0;
      a_full     <= 1'b0;
      b_full     <= 1'b0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      mac_clear  <= 1'b0;
      mac_enable <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      i_q        <= i_n;
      j_q        <= j_n;
      k_q        <= k_n;
      load_ready <= (state_n == S_IDLE);
      busy       <= (state_n != S_IDLE);
      mac_clear  <= clear_n;
      mac_enable <= enable_n;
      mac_a      <= a_n;
      mac_b      <= b_n;
      out_valid  <= (state_n == S_OUTPUT);
      done       <= done_n;

      if ((state == S_CAPTURE) && (state_n == S_OUTPUT)) begin
        out_data <= mac_result;
        out_row  <= i_q;
        out_col  <= j_q;
      end

      if (load_fire) begin
        if (load_sel) begin
          b_ptr <= (b_ptr == PTR_LAST) ? '0 : b_ptr + 1'b1;
          if (b_ptr == PTR_LAST) b_full <= 1'b1;
        end else begin
          a_ptr <= (a_ptr == PTR_LAST) ? '0 : a_ptr + 1'b1;
          if (a_ptr == PTR_LAST) a_full <= 1'b1;
        end
      end
    end
  end

  // Operand storage is not reset; the full flags gate its use.
  always_ff @(posedge clock) begin
    if (load_fire) begin
      if (load_sel) begin
        b_mem[b_ptr] <= load_data;
      end else begin
        a_mem[a_ptr] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mmac_operand_feeder.sv
// Bench for mmac_operand_feeder (M_SIZE=2): vector table, random runs against a plain matrix-multiply model.
module tb_mmac_operand_feeder;

  localparam int DW = 16;
  localparam int M  = 2;
  localparam int LAT = M + 3;

  typedef logic [M*M-1:0][DW-1:0] mat_t;
  typedef struct packed {
    mat_t a;
    mat_t b;
    mat_t c;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic          load_sel;
  logic [DW-1:0] load_data;
  logic          start;
  logic          abort;
  logic          busy;
  logic          mac_clear;
  logic          mac_enable;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [DW-1:0] mac_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [0:0]    out_row;
  logic [0:0]    out_col;
  logic          done;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int en_count = 0;

  mmac_operand_feeder #(.DATA_WIDTH(DW), .M_SIZE(M)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_data  (load_data),
    .start      (start),
`ifdef MMAC_FEEDER_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .mac_clear  (mac_clear),
    .mac_enable (mac_enable),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_result (mac_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Behavioural MAC: truncating accumulate, registered result.
  logic [DW-1:0] acc;
  always @(posedge clock) begin
    if (reset || mac_clear) acc <= '0;
    else if (mac_enable)    acc <= acc + mac_a * mac_b;
  end
  assign mac_result = acc;

  always @(negedge clock) begin
    if (done)       done_count++;
    if (mac_enable) en_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic mat_t mk(input logic [DW-1:0] e0, e1, e2, e3);
    mat_t m;
    m[0] = e0; m[1] = e1; m[2] = e2; m[3] = e3;
    return m;
  endfunction

  // Reference: C = A x B modulo 2^DW, row-major.
  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t c;
    logic [31:0] s;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        s = 0;
        for (int k = 0; k < M; k++) s = s + a[i*M+k] * b[k*M+j];
        c[i*M+j] = s[DW-1:0];
      end
    end
    return c;
  endfunction

  task automatic load_mat(input logic sel, input mat_t m);
    for (int e = 0; e < M*M; e++) begin
      load_valid = 1'b1;
      load_sel   = sel;
      load_data  = m[e];
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Start a run and check every element, latency, period and the done pulse.
  task automatic run_check(input string tag, input mat_t c_exp, input bit rand_ready, input int hold0);
    int  idx, cyc, prev_cyc, dc0;
    bit  seen, fire;
    dc0 = done_count;
    out_ready = (hold0 > 0) ? 1'b0 : 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_clear"}, 32'(mac_clear), 32'd1);
    idx = 0; seen = 0; prev_cyc = 0;
    while (idx < M*M && cyc < 400) begin
      fire = 1'b0;
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (idx == 0) check($sformatf("%s_latency", tag), 32'(cyc), 32'(LAT));
          else if (!rand_ready && hold0 == 0)
            check($sformatf("%s_period%0d", tag, idx), 32'(cyc - prev_cyc), 32'(LAT));
          prev_cyc = cyc;
          if (idx == 0 && hold0 > 0) begin
            for (int s = 0; s < hold0; s++) begin
              check($sformatf("%s_hold_valid%0d", tag, s), 32'(out_valid), 32'd1);
              check($sformatf("%s_hold_data%0d", tag, s), 32'(out_data), 32'(c_exp[0]));
              check($sformatf("%s_hold_en%0d", tag, s), 32'({mac_enable, mac_clear}), 32'd0);
              tick();
              cyc++;
            end
            out_ready = 1'b1;
          end
        end
        check($sformatf("%s_data%0d", tag, idx), 32'(out_data), 32'(c_exp[idx]));
        check($sformatf("%s_row%0d", tag, idx), 32'(out_row), 32'(idx / M));
        check($sformatf("%s_col%0d", tag, idx), 32'(out_col), 32'(idx % M));
        fire = out_ready;
      end
      tick();
      cyc++;
      if (fire) begin
        idx++;
        seen = 0;
        if (idx == M*M) begin
          check({tag, "_done"}, 32'(done), 32'd1);
          check({tag, "_idle"}, 32'({busy, load_ready}), 32'b01);
        end else begin
          check($sformatf("%s_nodone%0d", tag, idx), 32'(done), 32'd0);
        end
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    check({tag, "_finished"}, 32'(idx), 32'(M*M));
    tick();
    check({tag, "_done_once"}, 32'(done_count - dc0), 32'd1);
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t vecs[4];
  mat_t ra, rb;
  int   en0, dc0, nf;
  bit   f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{a: mk(1, 2, 3, 4),            b: mk(5, 6, 7, 8), c: mk(19, 22, 43, 50)};
    vecs[1] = '{a: mk(16'hFFFF, 1, 0, 0),     b: mk(2, 0, 0, 0), c: mk(16'hFFFE, 0, 0, 0)};
    vecs[2] = '{a: mk(1, 0, 0, 1),            b: mk(9, 8, 7, 6), c: mk(9, 8, 7, 6)};
    vecs[3] = '{a: mk(16'h8000, 16'h8000, 2, 3), b: mk(2, 2, 4, 5), c: mk(0, 16'h8000, 16'h10, 16'h13)};

    reset = 1'b1; load_valid = 0; load_sel = 0; load_data = '0;
    start = 0; abort = 0; out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mac", 32'({mac_clear, mac_enable, mac_a, mac_b}), 32'd0);
    check("rst_out", 32'({out_valid, out_data, out_row, out_col, done}), 32'd0);

    // Start with only A loaded must be ignored.
    load_mat(1'b0, vecs[0].a);
    en0 = en_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("halfload_busy%0d", c), 32'(busy), 32'd0);
      tick();
    end
    check("halfload_no_enable", 32'(en_count - en0), 32'd0);
    load_mat(1'b1, vecs[0].b);
    run_check("halfload_run", vecs[0].c, 1'b0, 0);

    for (int v = 0; v < 4; v++) begin
      load_mat(1'b0, vecs[v].a);
      load_mat(1'b1, vecs[v].b);
      run_check($sformatf("vec%0d", v), vecs[v].c, 1'b0, 0);
    end

    // Back-pressure on the first element; buffers persist from the reload below.
    load_mat(1'b0, vecs[0].a);
    load_mat(1'b1, vecs[0].b);
    run_check("stall", vecs[0].c, 1'b0, 10);
    run_check("rerun", vecs[0].c, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int e = 0; e < M*M; e++) begin
        ra[e] = (r < 4) ? DW'($urandom_range(0, 20)) : DW'($urandom);
        rb[e] = (r < 4) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      end
      load_mat(1'b0, ra);
      load_mat(1'b1, rb);
      run_check($sformatf("rand%0d", r), matmul(ra, rb), 1'b1, 0);
    end

    // Reset during FEED of C[1][0].
    load_mat(1'b0, vecs[0].a);
    load_mat(1'b1, vecs[0].b);
    dc0 = done_count;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nf = 0;
    for (int c = 0; c < 100 && nf < 2; c++) begin
      f = out_valid && out_ready;
      tick();
      if (f) nf++;
    end
    check("midrst_reached", 32'(nf), 32'd2);
    tick();
    check("midrst_feed_en", 32'(mac_enable), 32'd1);
    check("midrst_feed_a", 32'(mac_a), 32'd3);
    check("midrst_feed_b", 32'(mac_b), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", 32'(load_ready), 32'd1);
    check("midrst_zero", 32'({busy, mac_clear, mac_enable, mac_a, mac_b}), 32'd0);
    check("midrst_out_zero", 32'({out_valid, out_data, out_row, out_col, done}), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("midrst_ignore%0d", c), 32'(busy), 32'd0);
      tick();
    end
    check("midrst_no_done", 32'(done_count - dc0), 32'd0);
    load_mat(1'b0, vecs[0].a);
    load_mat(1'b1, vecs[0].b);
    run_check("postrst", vecs[0].c, 1'b0, 0);

`ifdef MMAC_FEEDER_ABORT_EN
    // Abort while C[0][1] is offered, then rerun from the stored buffers.
    dc0 = done_count;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nf = 0;
    for (int c = 0; c < 100 && nf < 1; c++) begin
      f = out_valid && out_ready;
      tick();
      if (f) begin
        nf++;
        out_ready = 1'b0;
      end
    end
    for (int c = 0; c < 100 && !out_valid; c++) tick();
    check("abort_at_01", 32'({out_valid, out_row, out_col}), 32'b101);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 32'({busy, load_ready}), 32'b01);
    check("abort_drop", 32'({out_valid, mac_clear, mac_enable, mac_a, mac_b, done}), 32'd0);
    tick();
    check("abort_no_done", 32'(done_count - dc0), 32'd0);
    run_check("after_abort", vecs[0].c, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
